sun_track_sequencer: RTL and testbench
======================================

SUN_TRACK_SEQUENCER -- requirements
Module: sun_track_sequencer

Interface
REQ-001 Parameter THRESH, default 50: error dead-band in ADC counts; no move when |error| <= THRESH.
REQ-002 Parameter MOVE_CYC, default 2000000: CLK cycles one axis is driven per move (20 ms at 100 MHz).
REQ-003 Parameter SETTLE_CYC, default 100000: CLK cycles idle after a move before the next sample request.
REQ-004 CLK  in  1  system clock, 100 MHz.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 MC  in  1  manual control; 1 = buttons pass to servos, sequencer parked.
REQ-007 BTN_H0, BTN_H1, BTN_V0, BTN_V1  in  1 each  manual cw/ccw buttons per axis.
REQ-008 LDR_TL, LDR_TR, LDR_BL, LDR_BR  in  12 each  unsigned light-sensor samples.
REQ-009 SMP_VALID  in  1  one-cycle strobe; all four LDR inputs valid this cycle.
REQ-010 H_LIM, V_LIM  in  1 each  servo at max pulse width; blocks cw on that axis.
REQ-011 SMP_REQ  out  1  level request for a new sample set.
REQ-012 H_BTN_0, H_BTN_1, V_BTN_0, V_BTN_1  out  1 each  direction commands to servo drivers (BTN_0 = cw, BTN_1 = ccw).
REQ-013 ES_H, ES_V  out  1 each  sweep enable of the axis currently owned.
REQ-014 STATE  out  3  current FSM state encoding, for debug.

Function
REQ-015 FSM states: IDLE=0, SAMPLE=1, EVAL_H=2, MOVE_H=3, EVAL_V=4, MOVE_V=5, SETTLE=6, MANUAL=7.
REQ-016 All outputs registered; no combinational path from any input to any output.
REQ-017 IDLE -> SAMPLE on the next cycle when MC=0.
REQ-018 SAMPLE: SMP_REQ=1; on SMP_VALID, latch all four LDR values, drop SMP_REQ on the next cycle, go to EVAL_H; SMP_VALID outside SAMPLE is ignored.
REQ-019 Horizontal error eh = (TL+BL) - (TR+BR); vertical error ev = (TL+TR) - (BL+BR); both 14-bit signed, computed from latched values, no overflow possible.
REQ-020 EVAL_H (1 cycle): eh > THRESH and H_LIM=0 -> MOVE_H cw; eh < -THRESH -> MOVE_H ccw; otherwise -> EVAL_V.
REQ-021 EVAL_V (1 cycle): same rule on ev with V_LIM -> MOVE_V; otherwise -> SETTLE.
REQ-022 MOVE_x: hold the axis direction pair (01 cw, 10 ccw) and ES_x=1 for exactly MOVE_CYC cycles, then -> SETTLE; the other axis is held at 00 (one axis owns the drive at a time).
REQ-023 If H_LIM (V_LIM) rises during a cw MOVE_H (MOVE_V), drop the pair to 00 the next cycle and go to SETTLE.
REQ-024 SETTLE: all direction pairs 00, count SETTLE_CYC cycles, then -> SAMPLE.
REQ-025 Horizontal axis is always evaluated first; a horizontal move defers the vertical evaluation to the next sample cycle.
REQ-026 Move and settle counters are 32-bit and clear on each state entry.
REQ-027 MC=1 in any state: next cycle -> MANUAL; counters cleared; SMP_REQ=0; ES_H=ES_V=0.
REQ-028 MANUAL: outputs are the buttons registered one cycle; both buttons of an axis = 1 -> 00; a cw button on a limited axis -> 00.
REQ-029 MANUAL -> IDLE when MC=0.

Reset
REQ-030 On RST=1: state IDLE, all direction pairs 00, SMP_REQ=0, ES_H=ES_V=0, STATE=0, counters and latched samples 0.
REQ-031 Reset asserted during MOVE_x drops the direction pair to 00 immediately, without waiting for a clock edge.

Verification
REQ-032 Scenario: TL=BL=1000, TR=BR=900, MOVE_CYC=20 -> H pair=01 for exactly 20 cycles, V pair 00, then SETTLE.
REQ-033 Scenario: eh=+40, ev=-200 -> no H move; V pair=10 (ccw) for MOVE_CYC cycles.
REQ-034 Scenario: eh=+51 with H_LIM=1 -> no H move, go to EVAL_V; eh=+51 with H_LIM rising at move cycle 5 -> pair 00 at cycle 6, SETTLE.
REQ-035 Scenario: MC=1 mid-MOVE_H, BTN_V0=1 -> H pair 00 and V pair 01 within 2 cycles; BTN_V0=BTN_V1=1 -> V pair 00.
REQ-036 Scenario: RST pulse mid-SETTLE -> all outputs at reset values before the next CLK edge; after release, SMP_REQ=1 two cycles later.
REQ-037 Scenario: SMP_VALID strobed during SETTLE -> ignored; the latched samples are unchanged.

Source files
------------

// File: rtl/sun_track_sequencer.sv
// Sun-tracking sequencer for a two-axis servo mount.
// Requests a sample set from four light sensors, computes horizontal and
// vertical imbalance, and drives one axis at a time for a fixed move time
// followed by a settle time. A manual mode passes buttons straight through.
//
// Ports:
//   CLK, RST            clock, asynchronous active-high reset
//   MC                  manual control (1 = buttons drive servos)
//   BTN_H0/H1, BTN_V0/V1 manual cw/ccw buttons per axis
//   LDR_TL/TR/BL/BR     12-bit light samples, valid on SMP_VALID
//   H_LIM, V_LIM        axis at max pulse width; blocks cw on that axis
//   SMP_REQ             level request for a new sample set
//   H_BTN_0/1, V_BTN_0/1 direction commands (BTN_0 = cw, BTN_1 = ccw)
//   ES_H, ES_V          sweep enable of the axis currently moving
//   STATE               current FSM state, debug
module sun_track_sequencer #(
  parameter int unsigned THRESH     = 50,
  parameter int unsigned MOVE_CYC   = 2000000,
  parameter int unsigned SETTLE_CYC = 100000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MC,
  input  logic        BTN_H0,
  input  logic        BTN_H1,
  input  logic        BTN_V0,
  input  logic        BTN_V1,
  input  logic [11:0] LDR_TL,
  input  logic [11:0] LDR_TR,
  input  logic [11:0] LDR_BL,
  input  logic [11:0] LDR_BR,
  input  logic        SMP_VALID,
  input  logic        H_LIM,
  input  logic        V_LIM,
  output logic        SMP_REQ,
  output logic        H_BTN_0,
  output logic        H_BTN_1,
  output logic        V_BTN_0,
  output logic        V_BTN_1,
  output logic        ES_H,
  output logic        ES_V,
  output logic [2:0]  STATE
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StSample = 3'd1;
  localparam logic [2:0] StEvalH  = 3'd2;
  localparam logic [2:0] StMoveH  = 3'd3;
  localparam logic [2:0] StEvalV  = 3'd4;
  localparam logic [2:0] StMoveV  = 3'd5;
  localparam logic [2:0] StSettle = 3'd6;
  localparam logic [2:0] StManual = 3'd7;

  localparam logic signed [13:0] Thresh     = 14'(THRESH);
  localparam logic [31:0]        MoveLast   = 32'(MOVE_CYC - 1);
  localparam logic [31:0]        SettleLast = 32'(SETTLE_CYC - 1);

  logic [2:0]  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [11:0] tl_q, tl_d, tr_q, tr_d, bl_q, bl_d, br_q, br_d;
  logic [1:0]  h_pair_q, h_pair_d, v_pair_q, v_pair_d;  // {ccw, cw}
  logic        smp_req_q, smp_req_d;
  logic        es_h_q, es_h_d, es_v_q, es_v_d;

  // Sums of two 12-bit values fit 13 bits; the signed difference fits 14.
  logic [12:0]        sum_left, sum_right, sum_top, sum_bot;
  logic signed [13:0] eh, ev;
  logic               h_cw, h_ccw, v_cw, v_ccw;

  always_comb begin
    sum_left  = {1'b0, tl_q} + {1'b0, bl_q};
    sum_right = {1'b0, tr_q} + {1'b0, br_q};
    sum_top   = {1'b0, tl_q} + {1'b0, tr_q};
    sum_bot   = {1'b0, bl_q} + {1'b0, br_q};
    eh        = $signed({1'b0, sum_left}) - $signed({1'b0, sum_right});
    ev        = $signed({1'b0, sum_top})  - $signed({1'b0, sum_bot});
    h_cw      = (eh > Thresh) && !H_LIM;
    h_ccw     = (eh < -Thresh);
    v_cw      = (ev > Thresh) && !V_LIM;
    v_ccw     = (ev < -Thresh);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    tl_d    = tl_q;
    tr_d    = tr_q;
    bl_d    = bl_q;
    br_d    = br_q;

    case (state_q)
      StIdle:   state_d = StSample;
      StSample: begin
        if (SMP_VALID) begin
          tl_d    = LDR_TL;
          tr_d    = LDR_TR;
          bl_d    = LDR_BL;
          br_d    = LDR_BR;
          state_d = StEvalH;
        end
      end
      StEvalH:  state_d = (h_cw || h_ccw) ? StMoveH : StEvalV;
      StMoveH: begin
        // A cw move aborts as soon as the limit is seen.
        if ((h_pair_q == 2'b01 && H_LIM) || cnt_q == MoveLast) state_d = StSettle;
      end
      StEvalV:  state_d = (v_cw || v_ccw) ? StMoveV : StSettle;
      StMoveV: begin
        if ((v_pair_q == 2'b01 && V_LIM) || cnt_q == MoveLast) state_d = StSettle;
      end
      StSettle: if (cnt_q == SettleLast) state_d = StSample;
      StManual: if (!MC) state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (MC) state_d = StManual;

    // Counter restarts from zero on every state entry.
    if (state_d == state_q &&
        (state_q == StMoveH || state_q == StMoveV || state_q == StSettle)) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = '0;
    end
  end

  // Outputs are registered from the next state so they line up with STATE.
  always_comb begin
    h_pair_d  = 2'b00;
    v_pair_d  = 2'b00;
    smp_req_d = (state_d == StSample);
    es_h_d    = (state_d == StMoveH);
    es_v_d    = (state_d == StMoveV);
    case (state_d)
      StMoveH:  h_pair_d = (state_q == StMoveH) ? h_pair_q : (h_cw ? 2'b01 : 2'b10);
      StMoveV:  v_pair_d = (state_q == StMoveV) ? v_pair_q : (v_cw ? 2'b01 : 2'b10);
      StManual: begin
        // Both buttons pressed cancels; cw is masked by the axis limit.
        h_pair_d = {BTN_H1 & ~BTN_H0, BTN_H0 & ~BTN_H1 & ~H_LIM};
        v_pair_d = {BTN_V1 & ~BTN_V0, BTN_V0 & ~BTN_V1 & ~V_LIM};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      tl_q      <= '0;
      tr_q      <= '0;
      bl_q      <= '0;
      br_q      <= '0;
      h_pair_q  <= 2'b00;
      v_pair_q  <= 2'b00;
      smp_req_q <= 1'b0;
      es_h_q    <= 1'b0;
      es_v_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tl_q      <= tl_d;
      tr_q      <= tr_d;
      bl_q      <= bl_d;
      br_q      <= br_d;
      h_pair_q  <= h_pair_d;
      v_pair_q  <= v_pair_d;
      smp_req_q <= smp_req_d;
      es_h_q    <= es_h_d;
      es_v_q    <= es_v_d;
    end
  end

  assign STATE   = state_q;
  assign SMP_REQ = smp_req_q;
  assign H_BTN_0 = h_pair_q[0];
  assign H_BTN_1 = h_pair_q[1];
  assign V_BTN_0 = v_pair_q[0];
  assign V_BTN_1 = v_pair_q[1];
  assign ES_H    = es_h_q;
  assign ES_V    = es_v_q;

endmodule

// File: tb/tb_sun_track_sequencer.sv
// Testbench for sun_track_sequencer: table of sample sets with expected
// moves, plus directed sequences for limit abort, manual mode, reset and
// stray sample strobes.
module tb_sun_track_sequencer;

  localparam int MoveCyc   = 20;
  localparam int SettleCyc = 10;

  logic        clk, rst, mc;
  logic        btn_h0, btn_h1, btn_v0, btn_v1;
  logic [11:0] ldr_tl, ldr_tr, ldr_bl, ldr_br;
  logic        smp_valid, h_lim, v_lim;
  logic        smp_req, h_btn_0, h_btn_1, v_btn_0, v_btn_1, es_h, es_v;
  logic [2:0]  state;
  logic [1:0]  hpair, vpair;

  assign hpair = {h_btn_1, h_btn_0};
  assign vpair = {v_btn_1, v_btn_0};

  int total = 0;
  int bad   = 0;

  sun_track_sequencer #(
    .THRESH    (50),
    .MOVE_CYC  (MoveCyc),
    .SETTLE_CYC(SettleCyc)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .MC       (mc),
    .BTN_H0   (btn_h0),
    .BTN_H1   (btn_h1),
    .BTN_V0   (btn_v0),
    .BTN_V1   (btn_v1),
    .LDR_TL   (ldr_tl),
    .LDR_TR   (ldr_tr),
    .LDR_BL   (ldr_bl),
    .LDR_BR   (ldr_br),
    .SMP_VALID(smp_valid),
    .H_LIM    (h_lim),
    .V_LIM    (v_lim),
    .SMP_REQ  (smp_req),
    .H_BTN_0  (h_btn_0),
    .H_BTN_1  (h_btn_1),
    .V_BTN_0  (v_btn_0),
    .V_BTN_1  (v_btn_1),
    .ES_H     (es_h),
    .ES_V     (es_v),
    .STATE    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] tl, tr, bl, br;
    logic        hlim, vlim;
    logic [1:0]  h_exp;
    int          hcnt_exp;
    logic [1:0]  v_exp;
    int          vcnt_exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Returns at a negedge with SMP_REQ high (or after the bound expires).
  task automatic wait_req(input string tag);
    int guard = 0;
    while (smp_req !== 1'b1 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_req_wait"}, {31'd0, smp_req}, 32'd1);
  endtask

  task automatic pulse_sample(input logic [11:0] tl, tr, bl, br);
    ldr_tl    = tl;
    ldr_tr    = tr;
    ldr_bl    = bl;
    ldr_br    = br;
    smp_valid = 1'b1;
    @(negedge clk);
    smp_valid = 1'b0;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st);
    int guard = 0;
    while (state !== st && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_state_wait"}, {29'd0, state}, {29'd0, st});
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int         hc = 0, vc = 0, ec = 0;
    logic [1:0] hp = 2'b00, vp = 2'b00;
    bit         done = 0;
    string      tag;
    tag   = $sformatf("vec%0d", idx);
    h_lim = v.hlim;
    v_lim = v.vlim;
    wait_req(tag);
    pulse_sample(v.tl, v.tr, v.bl, v.br);
    for (int g = 0; g < 200; g++) begin
      if (state == 3'd6) begin
        done = 1;
        break;
      end
      if (hpair != 2'b00) begin hc++; hp = hpair; end
      if (vpair != 2'b00) begin vc++; vp = vpair; end
      if (es_h || es_v) ec++;
      @(negedge clk);
    end
    check({tag, "_settle"}, {31'd0, done}, 32'd1);
    check({tag, "_hpair"}, {30'd0, hp}, {30'd0, v.h_exp});
    check({tag, "_hcnt"}, hc, v.hcnt_exp);
    check({tag, "_vpair"}, {30'd0, vp}, {30'd0, v.v_exp});
    check({tag, "_vcnt"}, vc, v.vcnt_exp);
    check({tag, "_es_cnt"}, ec, v.hcnt_exp + v.vcnt_exp);
    h_lim = 1'b0;
    v_lim = 1'b0;
  endtask

  initial begin
    int n;
    //             tl     tr     bl     br    hlim  vlim  h     hc  v     vc
    vecs[0]  = '{12'd1000, 12'd900, 12'd1000, 12'd900, 1'b0, 1'b0, 2'b01, 20, 2'b00, 0};
    vecs[1]  = '{12'd500, 12'd480, 12'd600, 12'd580, 1'b0, 1'b0, 2'b00, 0, 2'b10, 20};
    vecs[2]  = '{12'd526, 12'd500, 12'd525, 12'd500, 1'b1, 1'b0, 2'b00, 0, 2'b00, 0};
    vecs[3]  = '{12'd500, 12'd551, 12'd500, 12'd500, 1'b1, 1'b0, 2'b10, 20, 2'b00, 0};
    vecs[4]  = '{12'd550, 12'd500, 12'd500, 12'd500, 1'b0, 1'b0, 2'b00, 0, 2'b00, 0};
    vecs[5]  = '{12'd551, 12'd551, 12'd500, 12'd500, 1'b0, 1'b1, 2'b00, 0, 2'b00, 0};
    vecs[6]  = '{12'd551, 12'd551, 12'd500, 12'd500, 1'b0, 1'b0, 2'b00, 0, 2'b01, 20};
    vecs[7]  = '{12'd500, 12'd500, 12'd525, 12'd526, 1'b0, 1'b1, 2'b00, 0, 2'b10, 20};
    vecs[8]  = '{12'd4095, 12'd0, 12'd4095, 12'd0, 1'b0, 1'b0, 2'b01, 20, 2'b00, 0};
    vecs[9]  = '{12'd0, 12'd4095, 12'd0, 12'd4095, 1'b0, 1'b0, 2'b10, 20, 2'b00, 0};
    vecs[10] = '{12'd500, 12'd500, 12'd500, 12'd449, 1'b0, 1'b0, 2'b01, 20, 2'b00, 0};
    vecs[11] = '{12'd500, 12'd550, 12'd500, 12'd500, 1'b0, 1'b0, 2'b00, 0, 2'b00, 0};

    rst = 1'b1; mc = 1'b0;
    btn_h0 = 1'b0; btn_h1 = 1'b0; btn_v0 = 1'b0; btn_v1 = 1'b0;
    ldr_tl = '0; ldr_tr = '0; ldr_bl = '0; ldr_br = '0;
    smp_valid = 1'b0; h_lim = 1'b0; v_lim = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_outs", {24'd0, smp_req, hpair, vpair, es_h, es_v, 1'b0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_to_sample", {29'd0, state}, 32'd1);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // H_LIM rises during a cw horizontal move.
    wait_req("lim");
    pulse_sample(12'd500, 12'd500, 12'd500, 12'd449);
    n = 0;
    for (int g = 0; g < 100; g++) begin
      if (hpair == 2'b01) n++;
      if (n == 5) begin
        h_lim = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    check("lim_cw_cycles", n, 5);
    check("lim_hpair", {30'd0, hpair}, 32'd0);
    check("lim_state", {29'd0, state}, 32'd6);
    h_lim = 1'b0;

    // Manual takeover in the middle of a horizontal move.
    wait_req("man");
    pulse_sample(12'd1000, 12'd900, 12'd1000, 12'd900);
    n = 0;
    for (int g = 0; g < 100 && n < 3; g++) begin
      if (hpair == 2'b01) n++;
      @(negedge clk);
    end
    check("man_move_seen", n, 3);
    mc = 1'b1; btn_v0 = 1'b1;
    repeat (2) @(negedge clk);
    check("man_state", {29'd0, state}, 32'd7);
    check("man_hpair", {30'd0, hpair}, 32'd0);
    check("man_vpair_cw", {30'd0, vpair}, 32'd1);
    check("man_req_es", {29'd0, smp_req, es_h, es_v}, 32'd0);
    btn_v1 = 1'b1;
    repeat (2) @(negedge clk);
    check("man_vpair_both", {30'd0, vpair}, 32'd0);
    btn_v0 = 1'b0; btn_v1 = 1'b0; btn_h0 = 1'b1; h_lim = 1'b1;
    repeat (2) @(negedge clk);
    check("man_hcw_lim", {30'd0, hpair}, 32'd0);
    h_lim = 1'b0;
    repeat (2) @(negedge clk);
    check("man_hcw", {30'd0, hpair}, 32'd1);
    btn_h0 = 1'b0; btn_h1 = 1'b1;
    repeat (2) @(negedge clk);
    check("man_hccw", {30'd0, hpair}, 32'd2);
    btn_h1 = 1'b0; mc = 1'b0;
    @(negedge clk);
    check("man_exit_idle", {29'd0, state}, 32'd0);
    check("man_exit_pairs", {28'd0, hpair, vpair}, 32'd0);

    // Asynchronous reset during a move.
    wait_req("rstmv");
    pulse_sample(12'd1000, 12'd900, 12'd1000, 12'd900);
    wait_state("rstmv", 3'd3);
    check("rstmv_pre_hpair", {30'd0, hpair}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rstmv_hpair", {30'd0, hpair}, 32'd0);
    check("rstmv_es_state", {28'd0, es_h, state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset during settle.
    wait_req("rstst");
    pulse_sample(12'd550, 12'd500, 12'd500, 12'd500);
    wait_state("rstst", 3'd6);
    #2 rst = 1'b1;
    #1;
    check("rstst_state", {29'd0, state}, 32'd0);
    check("rstst_outs", {25'd0, smp_req, hpair, vpair, es_h, es_v}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rstst_req_after", {31'd0, smp_req}, 32'd1);
    @(negedge clk);

    // Sample strobe during settle is ignored.
    wait_req("stray");
    pulse_sample(12'd550, 12'd500, 12'd500, 12'd500);
    wait_state("stray", 3'd6);
    pulse_sample(12'd4095, 12'd0, 12'd4095, 12'd0);
    check("stray_state", {29'd0, state}, 32'd6);
    check("stray_outs", {27'd0, smp_req, hpair, vpair}, 32'd0);
    repeat (3) @(negedge clk);
    check("stray_still_settle", {29'd0, state}, 32'd6);
    check("stray_no_move", {28'd0, hpair, vpair}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
